word_serializer: RTL and testbench

- Upstream feeder for the 1010 sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on ser_x, which drives the detector's x input.
- A one-word holding buffer lets back-to-back words stream with no idle bit between them.
- When there is no data, ser_x is held at 0, which does not advance the detector out of its initial state.

---
 rtl/ser_pkg.sv | 14 +
 rtl/ser_hold_buf.sv | 32 +++
 rtl/word_serializer.sv | 120 ++++++++++++
 tb/tb_word_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and helpers for the word serializer.
// Imported by the hold buffer and the serializer top.
package ser_pkg;

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } ser_state_t;

   function automatic int ser_cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register between the handshake and the shifter.
// Lets the next word wait while the current one is still shifting.
module ser_hold_buf
   import ser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic             unload,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         dout <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         dout <= din;
         full <= 1'b1;
      end else if (unload) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder for the 1010 sequence detector.
// Streams accepted words one bit per clock on ser_x, gap-free.
module word_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_x,
   output logic             ser_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = ser_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   ser_state_t       state;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] hold_q;
   logic [WIDTH-1:0] load_src;
   logic             hold_full;
   logic             accept;
   logic             last;
   logic             hold_load;
   logic             hold_unload;
   logic             first_bit;
   logic             next_bit;

   assign in_ready    = !hold_full;
   assign accept      = in_valid && in_ready && !clear;
   assign last        = (state == S_SHIFT) && (cnt == LAST);
   assign cnt_nxt     = cnt + 1'b1;
   assign hold_load   = accept && (state == S_SHIFT) && !last;
   assign hold_unload = last && hold_full;
   assign busy        = (state == S_SHIFT) || hold_full;

   // hold is only ever full while shifting, so IDLE always loads in_data
   assign load_src  = hold_full ? hold_q : in_data;
   assign first_bit = (MSB_FIRST != 0) ? load_src[WIDTH-1] : load_src[0];
   assign next_bit  = (MSB_FIRST != 0) ? shreg[WIDTH-2] : shreg[1];

   ser_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .load   (hold_load),
      .unload (hold_unload),
      .din    (in_data),
      .dout   (hold_q),
      .full   (hold_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         shreg     <= '0;
         ser_x     <= 1'b0;
         ser_valid <= 1'b0;
         word_done <= 1'b0;
      end else if (clear) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ser_x     <= 1'b0;
         ser_valid <= 1'b0;
         word_done <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  state     <= S_SHIFT;
                  shreg     <= load_src;
                  cnt       <= '0;
                  ser_x     <= first_bit;
                  ser_valid <= 1'b1;
                  word_done <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (last) begin
                  if (hold_full || accept) begin
                     shreg     <= load_src;
                     cnt       <= '0;
                     ser_x     <= first_bit;
                     ser_valid <= 1'b1;
                     word_done <= 1'b0;
                  end else begin
                     state     <= S_IDLE;
                     cnt       <= '0;
                     ser_x     <= 1'b0;
                     ser_valid <= 1'b0;
                     word_done <= 1'b0;
                  end
               end else begin
                  if (MSB_FIRST != 0)
                     shreg <= {shreg[WIDTH-2:0], 1'b0};
                  else
                     shreg <= {1'b0, shreg[WIDTH-1:1]};
                  cnt       <= cnt_nxt;
                  ser_x     <= next_bit;
                  word_done <= (cnt_nxt == LAST);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench: MSB-first and LSB-first instances share the stimulus.
// Vectors list the expected bit stream in emission order (first bit = bit 7).
module tb_word_serializer;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic [7:0] in_data;
   logic       in_valid;

   logic m_ready, m_x, m_valid, m_done, m_busy;
   logic l_ready, l_x, l_valid, l_done, l_busy;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [7:0] data;
      logic [7:0] msb_seq;
      logic [7:0] lsb_seq;
   } vec_t;

   vec_t tbl[5];

   word_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (m_ready),
      .ser_x     (m_x),
      .ser_valid (m_valid),
      .word_done (m_done),
      .busy      (m_busy)
   );

   word_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (l_ready),
      .ser_x     (l_x),
      .ser_valid (l_valid),
      .word_done (l_done),
      .busy      (l_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " m_valid"}, m_valid, 1'b0);
      chk({tag, " m_x"}, m_x, 1'b0);
      chk({tag, " m_done"}, m_done, 1'b0);
      chk({tag, " m_busy"}, m_busy, 1'b0);
      chk({tag, " m_ready"}, m_ready, 1'b1);
      chk({tag, " l_valid"}, l_valid, 1'b0);
      chk({tag, " l_x"}, l_x, 1'b0);
   endtask

   task automatic send_word(input vec_t v);
      in_data  = v.data;
      in_valid = 1'b1;
      chk("acc ready", m_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("sw m_valid", m_valid, 1'b1);
         chk("sw m_x", m_x, v.msb_seq[7-i]);
         chk("sw l_x", l_x, v.lsb_seq[7-i]);
         chk("sw m_done", m_done, (i == 7));
         chk("sw busy", m_busy, 1'b1);
         tick();
      end
      chk_idle("sw end");
   endtask

   initial begin
      logic [15:0] m16;
      logic [15:0] l16;
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      clear    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;

      tbl[0] = '{8'hAA, 8'hAA, 8'h55};
      tbl[1] = '{8'h05, 8'h05, 8'hA0};
      tbl[2] = '{8'hF0, 8'hF0, 8'h0F};
      tbl[3] = '{8'h3C, 8'h3C, 8'h3C};
      tbl[4] = '{8'hC1, 8'hC1, 8'h83};

      // reset then idle
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_idle("rst");
         tick();
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle("idle");
      end

      // single words, both bit orders
      foreach (tbl[k]) send_word(tbl[k]);

      // back-to-back F0 then 0F
      m16 = 16'hF00F;
      l16 = 16'h0FF0;
      in_data  = 8'hF0;
      in_valid = 1'b1;
      tick();
      for (int k = 1; k <= 16; k++) begin
         if (k == 1) in_data = 8'h0F;
         if (k == 2) in_valid = 1'b0;
         chk("bb m_valid", m_valid, 1'b1);
         chk("bb m_x", m_x, m16[16-k]);
         chk("bb l_x", l_x, l16[16-k]);
         chk("bb m_done", m_done, (k == 8) || (k == 16));
         chk("bb m_ready", m_ready, !(k >= 2 && k <= 8));
         tick();
      end
      chk_idle("bb end");

      // clear mid-word with a word pending in hold
      in_data  = 8'hFF;
      in_valid = 1'b1;
      tick();
      in_data = 8'h55;
      tick();
      in_valid = 1'b0;
      tick();
      chk("clr pre x", m_x, 1'b1);
      chk("clr pre ready", m_ready, 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h81;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk_idle("clr");
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("clr drop valid", m_valid, 1'b0);
         chk("clr drop done", m_done, 1'b0);
      end

      // word offered during clear from idle is dropped
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk_idle("clr idle");
      tick();
      chk_idle("clr idle2");

      // async reset during bit 5 of AA
      in_data  = 8'hAA;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("ar pre valid", m_valid, 1'b1);
      chk("ar pre x", m_x, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("ar");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_idle("ar rel");
      send_word(tbl[4]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
